ysyx_25020037_axil_sram: RTL and testbench
==========================================

# ysyx_25020037_axil_sram

AXI4-Lite responder (slave) that backs the LSU data port with a word-addressed on-chip memory. It accepts read-address/read-data and write-address/write-data/write-response transactions from the LSU initiator. Each direction adds a programmable fixed latency so LSU stall handling can be exercised. Out-of-range accesses get an error response instead of touching memory.

## Interface
- ADDR_BASE, 32'h8000_0000, byte address of word 0
- DEPTH_WORDS, 1024, memory depth in 32-bit words (power of two)
- RD_LAT, 1, cycles from AR handshake to rvalid assertion (1..255)
- WR_LAT, 1, cycles from both-AW-and-W-captured to bvalid assertion (1..255)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- araddr  in  32  read byte address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  read response: 00 OKAY, 11 DECERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write byte address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables, bit i covers wdata[8i+7:8i]
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response: 00 OKAY, 11 DECERR
- bvalid  out  1  write response valid
- bready  in  1  write response ready

## Operation
- Address decode: in range iff ADDR_BASE <= addr < ADDR_BASE + 4*DEPTH_WORDS.
- Word index is (addr - ADDR_BASE) >> 2. addr[1:0] is ignored; wstrb is applied as given.
- Read FSM: R_IDLE -> R_WAIT -> R_RESP.
  - R_IDLE: arready=1. On arvalid&arready, latch araddr, load counter with RD_LAT-1, go to R_WAIT.
  - R_WAIT: arready=0, counter decrements. At 0, register rdata (the memory word, or 0 on DECERR) and rresp, set rvalid, go to R_RESP.
  - R_RESP: rvalid, rdata and rresp are held stable. On rvalid&rready, clear rvalid, set arready, go to R_IDLE.
- Write FSM: W_IDLE -> W_WAIT -> W_RESP. AW and W are captured independently and in either order.
  - W_IDLE: awready stays 1 until AW is captured. wready stays 1 until W is captured, whether or not wvalid is high. The LSU requires wready high while awvalid is pending.
  - When both AW and W are captured (possibly in the same cycle), go to W_WAIT and load the counter with WR_LAT-1. awready and wready are 0 from then on.
  - W_WAIT: at counter 0, commit the strobed bytes if in range (DECERR writes nothing), set bvalid and bresp, go to W_RESP.
  - W_RESP: on bvalid&bready, clear bvalid, set awready and wready, go to W_IDLE.
- The read and write FSMs are fully independent and may be busy at the same time.

## Timing
- Reset values: arready=1, awready=1, wready=1, rvalid=0, bvalid=0, rdata=0, rresp=00, bresp=00.
- Memory is not reset; its contents survive rst.
- Read latency: AR handshake at edge k gives rvalid high after edge k+RD_LAT. Returned data is the memory as of edge k+RD_LAT-1.
- Write latency: last of AW/W captured at edge k gives memory updated and bvalid high after edge k+WR_LAT.
- One outstanding transaction per direction. No back-to-back AR acceptance until the current R handshake completes.
- Read and write hitting the same word on the same edge: read returns the old data, write commits.
- rready or bready held high before valid: the handshake completes on the first cycle valid is high.
- rst asserted mid-transaction: both FSMs return to IDLE immediately. In-flight writes not yet committed are dropped; no response is issued.
- Counter is 8 bits. RD_LAT or WR_LAT of 0 is illegal and is flagged by an elaboration-time check.

## Structure
- Shared package: AXI response codes (RESP_OKAY=2'b00, RESP_DECERR=2'b11), FSM state encodings, and the latency counter width.
- Natural sub-module: ysyx_25020037_axil_lat_cnt, a loadable down-counter with a zero flag. It is instantiated once for reads and once for writes.
- The memory array is inferred inside the top module, with per-byte write enables.

## Test plan
- Reset, then read 0x8000_0000 with RD_LAT=1 -> arready=1 at reset; rvalid rises 1 cycle after the AR handshake; rdata=0x0000_0000 after the preload; rresp=00.
- AW=0x8000_0010 accepted first, W=0xDEAD_BEEF with wstrb=1111 two cycles later, then a read of the same address -> bvalid WR_LAT cycles after W capture, bresp=00; the read returns 0xDEAD_BEEF.
- wstrb=0001 with wdata=0x0000_00AA over 0x1122_3344 -> readback is 0x1122_33AA.
- Read of 0x7FFF_FFFC and write to 0x8000_1000 (DEPTH_WORDS=1024) -> rresp=11, rdata=0, bresp=11; memory is unchanged.
- RD_LAT=5 with rready held low for 3 cycles after rvalid -> rvalid appears 5 cycles after AR; rdata and rvalid stay stable until the handshake; arready stays 0 throughout.
- rst pulsed during W_WAIT -> bvalid never asserts; the target word keeps its old value; all ready signals return to 1.

Source files
------------

// File: rtl/ysyx_25020037_axil_sram_pkg.sv
// Shared definitions for the AXI4-Lite SRAM responder: response codes,
// FSM state encodings and the latency counter width.
package ysyx_25020037_axil_sram_pkg;

   localparam int CNT_W = 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      R_IDLE,
      R_WAIT,
      R_RESP
   } rd_state_t;

   typedef enum logic [1:0] {
      W_IDLE,
      W_WAIT,
      W_RESP
   } wr_state_t;

endpackage

// File: rtl/ysyx_25020037_axil_lat_cnt.sv
// Loadable down-counter with a zero flag, used to stretch each AXI
// direction by a fixed number of cycles.
module ysyx_25020037_axil_lat_cnt
   import ysyx_25020037_axil_sram_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt;

   // Load wins over decrement; the count parks at zero until reloaded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/ysyx_25020037_axil_sram.sv
// AXI4-Lite responder backing the LSU data port with a word-addressed
// on-chip memory; independent read and write FSMs with fixed latencies.
module ysyx_25020037_axil_sram
   import ysyx_25020037_axil_sram_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LAT      = 1,
   parameter int          WR_LAT      = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] araddr,
   input  logic        arvalid,
   output logic        arready,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rvalid,
   input  logic        rready,
   input  logic [31:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN  = 32'(4 * DEPTH_WORDS);

   if (RD_LAT < 1 || RD_LAT > 255) begin : g_bad_rd_lat
      $error("RD_LAT must be in 1..255");
   end
   if (WR_LAT < 1 || WR_LAT > 255) begin : g_bad_wr_lat
      $error("WR_LAT must be in 1..255");
   end

   logic [31:0] mem [DEPTH_WORDS];

   // ---------------- read side ----------------
   rd_state_t   rd_state, rd_next;
   logic [31:0] r_addr, rd_off;
   logic        rd_load, rd_dec, rd_zero, rd_in_range;

   // Below-base addresses wrap to a huge offset, so one compare covers both bounds.
   assign rd_off      = r_addr - ADDR_BASE;
   assign rd_in_range = (rd_off < SPAN);

   ysyx_25020037_axil_lat_cnt u_rd_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (rd_load),
      .load_val (CNT_W'(RD_LAT - 1)),
      .dec      (rd_dec),
      .zero     (rd_zero)
   );

   // Read state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_state <= R_IDLE;
      else     rd_state <= rd_next;
   end

   // Read next-state and handshake outputs.
   always_comb begin
      rd_next = rd_state;
      arready = 1'b0;
      rvalid  = 1'b0;
      rd_load = 1'b0;
      rd_dec  = 1'b0;
      case (rd_state)
         R_IDLE: begin
            arready = 1'b1;
            if (arvalid) begin
               rd_load = 1'b1;
               rd_next = R_WAIT;
            end
         end
         R_WAIT: begin
            if (rd_zero) rd_next = R_RESP;
            else         rd_dec  = 1'b1;
         end
         R_RESP: begin
            rvalid = 1'b1;
            if (rready) rd_next = R_IDLE;
         end
         default: rd_next = R_IDLE;
      endcase
   end

   // Latch the read address and register the response when the wait expires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         rdata  <= '0;
         rresp  <= RESP_OKAY;
      end else begin
         if (rd_load) r_addr <= araddr;
         if (rd_state == R_WAIT && rd_zero) begin
            rdata <= rd_in_range ? mem[rd_off[IDX_W+1:2]] : 32'h0;
            rresp <= rd_in_range ? RESP_OKAY : RESP_DECERR;
         end
      end
   end

   // ---------------- write side ----------------
   wr_state_t   wr_state, wr_next;
   logic [31:0] w_addr, w_data, wr_off;
   logic [3:0]  w_strb;
   logic        aw_got, w_got, aw_fire, w_fire;
   logic        wr_load, wr_dec, wr_zero, wr_commit, wr_in_range;

   assign wr_off      = w_addr - ADDR_BASE;
   assign wr_in_range = (wr_off < SPAN);

   ysyx_25020037_axil_lat_cnt u_wr_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (wr_load),
      .load_val (CNT_W'(WR_LAT - 1)),
      .dec      (wr_dec),
      .zero     (wr_zero)
   );

   // Write state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) wr_state <= W_IDLE;
      else     wr_state <= wr_next;
   end

   // Write next-state: AW and W are taken independently, then the wait starts.
   always_comb begin
      wr_next   = wr_state;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      aw_fire   = 1'b0;
      w_fire    = 1'b0;
      wr_load   = 1'b0;
      wr_dec    = 1'b0;
      wr_commit = 1'b0;
      case (wr_state)
         W_IDLE: begin
            awready = !aw_got;
            wready  = !w_got;
            aw_fire = awvalid && !aw_got;
            w_fire  = wvalid && !w_got;
            if ((aw_got || aw_fire) && (w_got || w_fire)) begin
               wr_load = 1'b1;
               wr_next = W_WAIT;
            end
         end
         W_WAIT: begin
            if (wr_zero) begin
               wr_commit = 1'b1;
               wr_next   = W_RESP;
            end else begin
               wr_dec = 1'b1;
            end
         end
         W_RESP: begin
            bvalid = 1'b1;
            if (bready) wr_next = W_IDLE;
         end
         default: wr_next = W_IDLE;
      endcase
   end

   // Capture flags, write payload and the response code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_got <= 1'b0;
         w_got  <= 1'b0;
         w_addr <= '0;
         w_data <= '0;
         w_strb <= '0;
         bresp  <= RESP_OKAY;
      end else begin
         aw_got <= wr_load ? 1'b0 : (aw_got || aw_fire);
         w_got  <= wr_load ? 1'b0 : (w_got || w_fire);
         if (aw_fire) w_addr <= awaddr;
         if (w_fire) begin
            w_data <= wdata;
            w_strb <= wstrb;
         end
         if (wr_commit) bresp <= wr_in_range ? RESP_OKAY : RESP_DECERR;
      end
   end

   // Byte-enabled memory write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_commit && wr_in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) mem[wr_off[IDX_W+1:2]][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_ysyx_25020037_axil_sram.sv
// Self-checking bench for the AXI4-Lite SRAM responder: directed cases plus
// randomized traffic checked against a word-array reference model.
module tb_ysyx_25020037_axil_sram;

   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          DEPTH  = 1024;
   localparam int          RD_LAT = 5;
   localparam int          WR_LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [31:0] model [DEPTH];
   bit          known [DEPTH];

   ysyx_25020037_axil_sram #(
      .ADDR_BASE   (BASE),
      .DEPTH_WORDS (DEPTH),
      .RD_LAT      (RD_LAT),
      .WR_LAT      (WR_LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arready (arready),
      .rdata   (rdata),
      .rresp   (rresp),
      .rvalid  (rvalid),
      .rready  (rready),
      .awaddr  (awaddr),
      .awvalid (awvalid),
      .awready (awready),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .wvalid  (wvalid),
      .wready  (wready),
      .bresp   (bresp),
      .bvalid  (bvalid),
      .bready  (bready)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit addr_ok(input logic [31:0] a);
      logic [63:0] a64, lo, hi;
      a64 = {32'h0, a};
      lo  = {32'h0, BASE};
      hi  = lo + 64'(4 * DEPTH);
      return (a64 >= lo) && (a64 < hi);
   endfunction

   function automatic int word_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int w;
      if (addr_ok(addr)) begin
         w = word_of(addr);
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[w][8*b +: 8] = data[8*b +: 8];
         if (strb == 4'hF) known[w] = 1'b1;
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input int hold, input bit early,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
      int n;
      logic [31:0] first_data;
      data = 'x;
      resp = 'x;
      lat  = -1;
      araddr  = addr;
      arvalid = 1'b1;
      rready  = early;
      n = 0;
      while (!arready && n < 50) begin
         tick();
         n++;
      end
      if (!arready) begin
         checkOutput("ar_timeout", 32'(arready), 32'd1);
         arvalid = 1'b0;
         rready  = 1'b0;
         return;
      end
      tick();
      arvalid = 1'b0;
      lat = 0;
      while (!rvalid && lat < 300) begin
         checkOutput("arready_busy", 32'(arready), 32'd0);
         tick();
         lat++;
      end
      if (!rvalid) begin
         checkOutput("r_timeout", 32'(rvalid), 32'd1);
         rready = 1'b0;
         return;
      end
      data = rdata;
      resp = rresp;
      first_data = rdata;
      if (!early) begin
         for (int h = 0; h < hold; h++) begin
            tick();
            checkOutput("rvalid_hold", 32'(rvalid), 32'd1);
            checkOutput("rdata_hold", rdata, first_data);
            checkOutput("arready_hold", 32'(arready), 32'd0);
         end
      end
      rready = 1'b1;
      tick();
      rready = 1'b0;
      checkOutput("rvalid_clear", 32'(rvalid), 32'd0);
      checkOutput("arready_back", 32'(arready), 32'd1);
   endtask

   // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW; 0: same cycle.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int gap, output logic [1:0] resp, output int lat);
      int  aw_at, w_at, c;
      bit  aw_done, w_done, aw_hs, w_hs;
      resp    = 'x;
      lat     = -1;
      aw_at   = (gap > 0) ? 0 : -gap;
      w_at    = (gap > 0) ? gap : 0;
      aw_done = 1'b0;
      w_done  = 1'b0;
      c = 0;
      checkOutput("awready_idle", 32'(awready), 32'd1);
      checkOutput("wready_idle", 32'(wready), 32'd1);
      while (!(aw_done && w_done) && c < 50) begin
         awvalid = !aw_done && (c >= aw_at);
         awaddr  = addr;
         wvalid  = !w_done && (c >= w_at);
         wdata   = data;
         wstrb   = strb;
         if (!w_done) checkOutput("wready_pending", 32'(wready), 32'd1);
         if (!aw_done) checkOutput("awready_pending", 32'(awready), 32'd1);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         c++;
         if (aw_hs) aw_done = 1'b1;
         if (w_hs)  w_done  = 1'b1;
      end
      awvalid = 1'b0;
      wvalid  = 1'b0;
      if (!(aw_done && w_done)) begin
         checkOutput("aw_w_timeout", 32'(aw_done && w_done), 32'd1);
         return;
      end
      lat = 0;
      while (!bvalid && lat < 300) begin
         checkOutput("awready_busy", 32'(awready), 32'd0);
         tick();
         lat++;
      end
      if (!bvalid) begin
         checkOutput("b_timeout", 32'(bvalid), 32'd1);
         return;
      end
      resp   = bresp;
      bready = 1'b1;
      tick();
      bready = 1'b0;
      checkOutput("bvalid_clear", 32'(bvalid), 32'd0);
   endtask

   task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int gap);
      logic [1:0] resp;
      int lat;
      axi_write(addr, data, strb, gap, resp, lat);
      checkOutput({tag, "_bresp"}, 32'(resp), addr_ok(addr) ? 32'd0 : 32'd3);
      checkOutput({tag, "_blat"}, 32'(lat), 32'(WR_LAT));
      model_write(addr, data, strb);
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input int hold, input bit early);
      logic [31:0] data;
      logic [1:0]  resp;
      int lat;
      axi_read(addr, hold, early, data, resp, lat);
      checkOutput({tag, "_rlat"}, 32'(lat), 32'(RD_LAT));
      if (addr_ok(addr)) begin
         checkOutput({tag, "_rresp"}, 32'(resp), 32'd0);
         if (known[word_of(addr)]) checkOutput({tag, "_rdata"}, data, model[word_of(addr)]);
      end else begin
         checkOutput({tag, "_rresp"}, 32'(resp), 32'd3);
         checkOutput({tag, "_rdata"}, data, 32'd0);
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r <= 5)      a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      else if (r <= 7) a = BASE + 32'(4 * DEPTH - 4) - 32'(4 * $urandom_range(0, 3));
      else if (r == 8) a = BASE - 32'(4 * $urandom_range(1, 4));
      else             a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 4));
      return a;
   endfunction

   task automatic applyStimulus(input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = rand_addr();
         if ($urandom_range(0, 1) == 1)
            do_write("rnd_wr", a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2);
         else
            do_read("rnd_rd", a, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model[i] = '0;
         known[i] = 1'b0;
      end

      // Reset values, sampled while reset is held.
      tick();
      tick();
      checkOutput("rst_arready", 32'(arready), 32'd1);
      checkOutput("rst_awready", 32'(awready), 32'd1);
      checkOutput("rst_wready", 32'(wready), 32'd1);
      checkOutput("rst_rvalid", 32'(rvalid), 32'd0);
      checkOutput("rst_bvalid", 32'(bvalid), 32'd0);
      checkOutput("rst_rdata", rdata, 32'd0);
      checkOutput("rst_rresp", 32'(rresp), 32'd0);
      checkOutput("rst_bresp", 32'(bresp), 32'd0);
      rst = 1'b0;
      tick();

      // Preload word 0 with zero, then read it back.
      do_write("pre0", BASE, 32'h0, 4'hF, 0);
      do_read("rd0", BASE, 0, 1'b0);

      // AW two cycles ahead of W, then read back.
      do_write("aw_first", BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 2);
      do_read("rd_deadbeef", BASE + 32'h10, 0, 1'b0);

      // W ahead of AW.
      do_write("w_first", BASE + 32'h14, 32'hCAFE_F00D, 4'hF, -2);
      do_read("rd_cafe", BASE + 32'h14, 0, 1'b0);

      // Single-byte strobe merge.
      do_write("strb_full", BASE + 32'h18, 32'h1122_3344, 4'hF, 0);
      do_write("strb_one", BASE + 32'h18, 32'h0000_00AA, 4'h1, 0);
      do_read("rd_strb", BASE + 32'h18, 0, 1'b0);
      checkOutput("strb_model", model[6], 32'h1122_33AA);

      // Boundaries: last word in range, one below base, one past the end.
      do_write("last_word", BASE + 32'hFFC, 32'h0F0F_A5A5, 4'hF, 1);
      do_read("rd_last", BASE + 32'hFFC, 0, 1'b0);
      do_read("rd_below", 32'h7FFF_FFFC, 0, 1'b0);
      do_write("wr_past", BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0);
      do_read("rd_word0_after_oor", BASE, 0, 1'b0);
      do_read("rd_last_after_oor", BASE + 32'hFFC, 0, 1'b0);

      // Back-pressure on R and rready held high early.
      do_read("rd_hold3", BASE + 32'h10, 3, 1'b0);
      do_read("rd_early", BASE + 32'h14, 0, 1'b1);

      // Reset during the write wait: the write must be dropped.
      do_write("rst_pre", BASE + 32'h20, 32'h55AA_55AA, 4'hF, 0);
      awaddr  = BASE + 32'h20;
      awvalid = 1'b1;
      wdata   = 32'h0BAD_F00D;
      wstrb   = 4'hF;
      wvalid  = 1'b1;
      tick();
      awvalid = 1'b0;
      wvalid  = 1'b0;
      tick();
      rst = 1'b1;
      #2;
      checkOutput("midrst_awready", 32'(awready), 32'd1);
      checkOutput("midrst_wready", 32'(wready), 32'd1);
      checkOutput("midrst_arready", 32'(arready), 32'd1);
      checkOutput("midrst_bvalid", 32'(bvalid), 32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checkOutput("midrst_no_b", 32'(bvalid), 32'd0);
         tick();
      end
      do_read("rd_after_rst", BASE + 32'h20, 0, 1'b0);

      // Initialise the random window, then random traffic.
      for (int i = 0; i < 16; i++) do_write("init_lo", BASE + 32'(4 * i), $urandom, 4'hF, 0);
      for (int i = 0; i < 4; i++) do_write("init_hi", BASE + 32'(4 * DEPTH - 4 - 4 * i), $urandom, 4'hF, 0);
      applyStimulus(200);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
